dmem_io_bridge: RTL and testbench

DMEM_IO_BRIDGE -- requirements
Module: dmem_io_bridge

---
 rtl/dmem_io_bridge_if.sv | 24 ++
 rtl/dmem_io_bridge.sv | 147 ++++++++++++++
 tb/tb_dmem_io_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_io_bridge_if.sv
// CPU data-port / BRAM port-B bus bundle for dmem_io_bridge.
// The bridge sits on the slave side; the CPU and BRAM side uses the master view.
interface dmem_io_bridge_if;
  logic        dmem_en;
  logic        dmem_we;
  logic [8:0]  dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;
  logic        bram_en;
  logic        bram_we;
  logic [8:0]  bram_addr;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;

  modport slave (
    input  dmem_en, dmem_we, dmem_addr, dmem_din, bram_dout,
    output dmem_dout, bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output dmem_en, dmem_we, dmem_addr, dmem_din, bram_dout,
    input  dmem_dout, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/dmem_io_bridge.sv
// Splits the CPU data port between BRAM and a 16-word I/O window (LED, SW, KEY, HEX, timer).
// Define IO_TIMER_EN to build the TIMER/TICK registers and their prescaler.
module dmem_io_bridge #(
  parameter int unsigned PRESCALE = 50000,
  parameter logic [8:0]  IO_BASE  = 9'h1F0
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_io_bridge_if.slave  bus,
  input  logic [9:0]       sw,
  input  logic [3:0]       key,
  output logic [9:0]       led,
  output logic [15:0]      hex
);

  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("dmem_io_bridge: PRESCALE must be in 2..65535");
  end

  localparam logic [3:0] OFS_LED   = 4'd0;
  localparam logic [3:0] OFS_SW    = 4'd1;
  localparam logic [3:0] OFS_KEY   = 4'd2;
  localparam logic [3:0] OFS_HEX   = 4'd3;
  localparam logic [3:0] OFS_TIMER = 4'd4;
  localparam logic [3:0] OFS_TICK  = 4'd5;

  logic        is_io;
  logic [3:0]  ofs;
  logic        io_wr;
  logic [9:0]  addr_ext;
  logic [15:0] rd_mux;
  logic [15:0] timer_rd;
  logic        tick_rd;

  logic [9:0]  led_q, led_d;
  logic [15:0] hex_q, hex_d;
  logic [9:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [3:0]  key_meta_q, key_meta_d, key_sync_q, key_sync_d;
  logic        sel_io_q, sel_io_d;
  logic [15:0] io_rd_q, io_rd_d;

  // 10-bit compare so a window at the top of the address space cannot wrap.
  always_comb begin
    addr_ext = {1'b0, bus.dmem_addr};
    is_io    = (addr_ext >= {1'b0, IO_BASE}) && (addr_ext <= ({1'b0, IO_BASE} + 10'd15));
    ofs      = bus.dmem_addr[3:0] - IO_BASE[3:0];
    io_wr    = bus.dmem_en && bus.dmem_we && is_io;
  end

  assign bus.bram_en   = bus.dmem_en && !is_io;
  assign bus.bram_we   = bus.dmem_we && !is_io;
  assign bus.bram_addr = bus.dmem_addr;
  assign bus.bram_din  = bus.dmem_din;

`ifdef IO_TIMER_EN
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d, timer_q, timer_d;
  logic        tick_q, tick_d, wrap;

  always_comb begin
    wrap    = (presc_q == PRESC_MAX);
    presc_d = wrap ? 16'd0 : presc_q + 16'd1;
    timer_d = timer_q;
    tick_d  = tick_q;
    if (io_wr && ofs == OFS_TIMER) begin
      timer_d = bus.dmem_din;
      presc_d = 16'd0;
    end else if (wrap) begin
      timer_d = timer_q + 16'd1;
    end
    if (io_wr && ofs == OFS_TICK && bus.dmem_din[0]) tick_d = 1'b0;
    // A tick landing on the clearing write must not be lost.
    if (wrap) tick_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      timer_q <= timer_d;
      tick_q  <= tick_d;
    end
  end

  assign timer_rd = timer_q;
  assign tick_rd  = tick_q;
`else
  assign timer_rd = '0;
  assign tick_rd  = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_LED:   rd_mux = {6'd0, led_q};
      OFS_SW:    rd_mux = {6'd0, sw_sync_q};
      OFS_KEY:   rd_mux = {12'd0, key_sync_q};
      OFS_HEX:   rd_mux = hex_q;
      OFS_TIMER: rd_mux = timer_rd;
      OFS_TICK:  rd_mux = {15'd0, tick_rd};
      default:   rd_mux = '0;
    endcase
  end

  // Read word samples pre-write register state, so a write cycle returns old data.
  always_comb begin
    led_d      = (io_wr && ofs == OFS_LED) ? bus.dmem_din[9:0] : led_q;
    hex_d      = (io_wr && ofs == OFS_HEX) ? bus.dmem_din : hex_q;
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    key_meta_d = key;
    key_sync_d = key_meta_q;
    sel_io_d   = bus.dmem_en ? is_io : sel_io_q;
    io_rd_d    = (bus.dmem_en && is_io) ? rd_mux : io_rd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q      <= '0;
      hex_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '0;
      key_sync_q <= '0;
      sel_io_q   <= 1'b0;
      io_rd_q    <= '0;
    end else begin
      led_q      <= led_d;
      hex_q      <= hex_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      sel_io_q   <= sel_io_d;
      io_rd_q    <= io_rd_d;
    end
  end

  assign bus.dmem_dout = sel_io_q ? io_rd_q : bus.bram_dout;
  assign led           = led_q;
  assign hex           = hex_q;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Directed bench for dmem_io_bridge: vector table plus timer and reset sequences.
module tb_dmem_io_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  led;
  logic [15:0] hex;
  int          checks = 0;
  int          errors = 0;

  dmem_io_bridge_if bus ();

  dmem_io_bridge #(.PRESCALE(4), .IO_BASE(9'h1F0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .sw(sw), .key(key), .led(led), .hex(hex)
  );

  always #5 clk = ~clk;

  // Simple read-first synchronous BRAM behind port B.
  logic [15:0] mem [0:511];
  logic [15:0] bram_q = '0;
  assign bus.bram_dout = bram_q;
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
      bram_q <= mem[bus.bram_addr];
    end
  end

  typedef struct {
    string       name;
    logic        en;
    logic        we;
    logic [8:0]  addr;
    logic [15:0] din;
    logic        chk;
    logic [15:0] dout;
    logic        ben;
    logic        bwe;
    logic [9:0]  led;
    logic [15:0] hex;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic en, logic we, logic [8:0] a, logic [15:0] d,
                              logic chk, logic [15:0] dout, logic ben, logic bwe,
                              logic [9:0] l, logic [15:0] h);
    vec_t v;
    v.name = n; v.en = en; v.we = we; v.addr = a; v.din = d; v.chk = chk;
    v.dout = dout; v.ben = ben; v.bwe = bwe; v.led = l; v.hex = h;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(logic en, logic we, logic [8:0] a, logic [15:0] d);
    bus.dmem_en = en; bus.dmem_we = we; bus.dmem_addr = a; bus.dmem_din = d;
  endtask

  task automatic acc(logic en, logic we, logic [8:0] a, logic [15:0] d);
    drive(en, we, a, d);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl.push_back(mk("wr_bram_010",   1, 1, 9'h010, 16'h1234, 0, 16'h0000, 1, 1, 10'h000, 16'h0000));
    tbl.push_back(mk("rd_bram_010",   1, 0, 9'h010, 16'h0000, 1, 16'h1234, 1, 0, 10'h000, 16'h0000));
    tbl.push_back(mk("wr_led",        1, 1, 9'h1F0, 16'h03FF, 0, 16'h0000, 0, 0, 10'h3FF, 16'h0000));
    tbl.push_back(mk("rd_led",        1, 0, 9'h1F0, 16'h0000, 1, 16'h03FF, 0, 0, 10'h3FF, 16'h0000));
    tbl.push_back(mk("wr_hex",        1, 1, 9'h1F3, 16'hFFFF, 0, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_hex",        1, 0, 9'h1F3, 16'h0000, 1, 16'hFFFF, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_bram_again", 1, 0, 9'h010, 16'h0000, 1, 16'h1234, 1, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("idle_hold",     0, 0, 9'h1F0, 16'h0000, 1, 16'h1234, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_sw",         1, 0, 9'h1F1, 16'h0000, 1, 16'h02A5, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("wr_sw_ignored", 1, 1, 9'h1F1, 16'h0000, 0, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_sw_again",   1, 0, 9'h1F1, 16'h0000, 1, 16'h02A5, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_unused_1fa", 1, 0, 9'h1FA, 16'h0000, 1, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("wr_unused_1fa", 1, 1, 9'h1FA, 16'h1234, 0, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_unused_chk", 1, 0, 9'h1FA, 16'h0000, 1, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_key",        1, 0, 9'h1F2, 16'h0000, 1, 16'h000A, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("wr_key_ignored",1, 1, 9'h1F2, 16'hFFFF, 0, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_key_again",  1, 0, 9'h1F2, 16'h0000, 1, 16'h000A, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("wr_bram_1ef",   1, 1, 9'h1EF, 16'hBEEF, 0, 16'h0000, 1, 1, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_bram_1ef",   1, 0, 9'h1EF, 16'h0000, 1, 16'hBEEF, 1, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("wr_io_1ff",     1, 1, 9'h1FF, 16'h5A5A, 0, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("rd_io_1ff",     1, 0, 9'h1FF, 16'h0000, 1, 16'h0000, 0, 0, 10'h3FF, 16'hFFFF));
    tbl.push_back(mk("wr_led_upper",  1, 1, 9'h1F0, 16'hFC15, 0, 16'h0000, 0, 0, 10'h015, 16'hFFFF));
    tbl.push_back(mk("rd_led_upper",  1, 0, 9'h1F0, 16'h0000, 1, 16'h0015, 0, 0, 10'h015, 16'hFFFF));

    rst_n = 1'b0;
    sw    = 10'h2A5;
    key   = 4'hA;
    drive(0, 0, 9'h000, 16'h0000);
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_led", {6'd0, led}, 16'h0000);
    chk("reset_hex", hex, 16'h0000);
    chk("reset_dout_bram", bus.dmem_dout, bram_q);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].din);
      #1;
      chk({tbl[i].name, "_bram_en"}, {15'd0, bus.bram_en}, {15'd0, tbl[i].ben});
      chk({tbl[i].name, "_bram_we"}, {15'd0, bus.bram_we}, {15'd0, tbl[i].bwe});
      @(posedge clk); #1;
      if (tbl[i].chk) chk({tbl[i].name, "_dout"}, bus.dmem_dout, tbl[i].dout);
      chk({tbl[i].name, "_led"}, {6'd0, led}, {6'd0, tbl[i].led});
      chk({tbl[i].name, "_hex"}, hex, tbl[i].hex);
    end

`ifdef IO_TIMER_EN
    acc(1, 1, 9'h1F4, 16'hFFFF);
    repeat (4) acc(0, 0, 9'h000, 16'h0000);
    acc(1, 0, 9'h1F4, 16'h0000); chk("timer_wrapped", bus.dmem_dout, 16'h0000);
    acc(1, 0, 9'h1F5, 16'h0000); chk("tick_set", bus.dmem_dout, 16'h0001);
    acc(0, 0, 9'h000, 16'h0000);
    acc(1, 1, 9'h1F5, 16'h0001);
    acc(1, 0, 9'h1F5, 16'h0000); chk("tick_set_wins", bus.dmem_dout, 16'h0001);
    acc(1, 1, 9'h1F5, 16'h0001);
    acc(1, 0, 9'h1F5, 16'h0000); chk("tick_cleared", bus.dmem_dout, 16'h0000);
    acc(1, 0, 9'h1F4, 16'h0000); chk("timer_one", bus.dmem_dout, 16'h0001);
`else
    acc(1, 1, 9'h1F4, 16'h0055);
    acc(1, 0, 9'h1F4, 16'h0000); chk("no_timer_rd4", bus.dmem_dout, 16'h0000);
    acc(1, 1, 9'h1F5, 16'h0001);
    acc(1, 0, 9'h1F5, 16'h0000); chk("no_timer_rd5", bus.dmem_dout, 16'h0000);
`endif

    // Reset in the middle of traffic: LED write then BRAM read, then reset on an I/O read.
    acc(1, 1, 9'h1F0, 16'h0155);
    chk("led_155", {6'd0, led}, 16'h0155);
    acc(1, 0, 9'h010, 16'h0000);
    chk("pre_rst_bram", bus.dmem_dout, 16'h1234);
    rst_n = 1'b0;
    drive(1, 1, 9'h020, 16'h9999);
    #1;
    chk("rst_pass_we", {15'd0, bus.bram_we}, 16'h0001);
    chk("rst_pass_addr", {7'd0, bus.bram_addr}, 16'h0020);
    acc(1, 0, 9'h1F0, 16'h0000);
    rst_n = 1'b1;
    drive(0, 0, 9'h000, 16'h0000);
    #1;
    chk("rst_led", {6'd0, led}, 16'h0000);
    chk("rst_hex", hex, 16'h0000);
    chk("rst_dout_bram", bus.dmem_dout, 16'h1234);
    rst_n = 1'b0;
    acc(1, 1, 9'h1F3, 16'h7777);
    rst_n = 1'b1;
    chk("rst_discard_hex", hex, 16'h0000);
    acc(1, 0, 9'h1F4, 16'h0000);
    chk("rst_timer", bus.dmem_dout, 16'h0000);
    acc(1, 0, 9'h1F0, 16'h0000);
    chk("rst_led_rd", bus.dmem_dout, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
